// File: rtl/dino_pkg.sv
`timescale 1ns/1ps
// dino_pkg: shared screen/obstacle constants,
// scheduler FSM encoding and the obstacle type fold.
package dino_pkg;
  localparam int SCREEN_W_PX = 640;
  localparam int OBS_TYPE_W = 3;
  localparam int NUM_OBS_TYPES = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FROZEN
  } state_t;

  // fold the 3 LFSR bits onto the 6 legal types
  function automatic logic [OBS_TYPE_W-1:0] fold_type(
    input logic [2:0] r
  );
    logic [2:0] lim;
    lim = 3'(NUM_OBS_TYPES);
    return (r < lim) ? r : r - 3'd4;
  endfunction
endpackage

// File: rtl/obstacle_scheduler_if.sv
`timescale 1ns/1ps
// obstacle_scheduler_if: game control in,
// packed obstacle slot state out.
interface obstacle_scheduler_if #(
  parameter int NUM_OBS = 3,
  parameter int POS_W = 8
);
  logic i_game_tick;
  logic i_game_start;
  logic i_game_frozen;
  logic [7:0] i_rng;
  logic [NUM_OBS*POS_W-1:0] o_obs_pos;
  logic [NUM_OBS*3-1:0] o_obs_type;
  logic [NUM_OBS-1:0] o_obs_active;
  logic [2:0] o_speed;
  logic o_spawn_pulse;

  modport master (
    output i_game_tick,
    output i_game_start,
    output i_game_frozen,
    output i_rng,
    input o_obs_pos,
    input o_obs_type,
    input o_obs_active,
    input o_speed,
    input o_spawn_pulse
  );

  modport slave (
    input i_game_tick,
    input i_game_start,
    input i_game_frozen,
    input i_rng,
    output o_obs_pos,
    output o_obs_type,
    output o_obs_active,
    output o_speed,
    output o_spawn_pulse
  );
endinterface

// File: rtl/obstacle_scheduler_slot.sv
`timescale 1ns/1ps
// obstacle_slot: one obstacle channel; spawns at
// the right edge and walks left by speed per tick.
module obstacle_slot
  import dino_pkg::*;
#(
  parameter int POS_W = 8,
  parameter int GEN_LINE = 70,
  parameter int OFFSCREEN = 160
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick_en,
  input  logic [2:0] speed,
  input  logic spawn_en,
  input  logic [OBS_TYPE_W-1:0] spawn_type,
  output logic [POS_W-1:0] pos,
  output logic [OBS_TYPE_W-1:0] obs_type,
  output logic active,
  output logic beyond
);
  localparam logic [POS_W-1:0] OFF_P = POS_W'(OFFSCREEN);
  localparam logic [POS_W-1:0] GEN_P = POS_W'(GEN_LINE);

  logic [POS_W-1:0] spd_w;

  assign spd_w = {{(POS_W-3){1'b0}}, speed};

  // slot still right of the spawn line blocks new spawns
  assign beyond = active && (pos > GEN_P);

  // spawn, move or expire the slot on a running tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= OFF_P;
      obs_type <= '0;
      active <= 1'b0;
    end else if (clear) begin
      pos <= OFF_P;
      obs_type <= '0;
      active <= 1'b0;
    end else if (spawn_en) begin
      pos <= OFF_P - 1'b1;
      obs_type <= spawn_type;
      active <= 1'b1;
    end else if (tick_en && active) begin
      if (pos >= spd_w) begin
        pos <= pos - spd_w;
      end else begin
        pos <= OFF_P;
        active <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/obstacle_scheduler.sv
`timescale 1ns/1ps
// obstacle_scheduler: NUM_OBS obstacle slots with LFSR
// spawning, a randomised holdoff and ramping speed.
module obstacle_scheduler
  import dino_pkg::*;
#(
  parameter int CONV = 2,
  parameter int NUM_OBS = 3,
  parameter int GEN_LINE = 70,
  parameter int MIN_GAP = 40,
  parameter int SPEED_INIT = 1,
  parameter int SPEED_MAX = 4,
  parameter int RAMP_TICKS = 600
) (
  input logic clk,
  input logic rst,
  obstacle_scheduler_if.slave bus
);
  localparam int POS_W = 10 - CONV;
  localparam int OFFSCREEN = SCREEN_W_PX >> CONV;
  localparam int IDX_W = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
  localparam int HOLD_W = $clog2(MIN_GAP + 32) + 1;
  localparam int RAMP_W = $clog2(RAMP_TICKS + 1);
  localparam logic [2:0] SPD_INIT = 3'(SPEED_INIT);
  localparam logic [2:0] SPD_MAX = 3'(SPEED_MAX);
  localparam logic [HOLD_W-1:0] GAP = HOLD_W'(MIN_GAP);
  localparam logic [RAMP_W-1:0] RAMP_END = RAMP_W'(RAMP_TICKS - 1);

  state_t state, state_nxt;
  logic clear, run_tick, spawn_go, free_any;
  logic [IDX_W-1:0] free_idx;
  logic [NUM_OBS-1:0] active, beyond, spawn_vec;
  logic [NUM_OBS*POS_W-1:0] pos_all;
  logic [NUM_OBS*3-1:0] type_all;
  logic [OBS_TYPE_W-1:0] spawn_type;
  logic [HOLD_W-1:0] holdoff_q;
  logic [RAMP_W-1:0] ramp_q;
  logic [2:0] speed_q;
  logic pulse_q;

  assign spawn_type = fold_type(bus.i_rng[2:0]);

  // game state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else state <= state_nxt;
  end

  // start wins over tick/frozen; only RUN ticks count
  always_comb begin
    state_nxt = state;
    clear = 1'b0;
    run_tick = 1'b0;
    if (bus.i_game_start) begin
      state_nxt = ST_RUN;
      clear = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_RUN: begin
          if (bus.i_game_frozen) state_nxt = ST_FROZEN;
          else run_tick = bus.i_game_tick;
        end
        ST_FROZEN: begin
          if (!bus.i_game_frozen) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // lowest-index free slot from the pre-tick mask
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_OBS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign spawn_go = run_tick && (holdoff_q == '0)
                    && free_any && !(|beyond);

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_slot
    assign spawn_vec[g] = spawn_go && (free_idx == IDX_W'(g));

    obstacle_slot #(
      .POS_W(POS_W),
      .GEN_LINE(GEN_LINE),
      .OFFSCREEN(OFFSCREEN)
    ) u_slot (
      .clk(clk),
      .rst(rst),
      .clear(clear),
      .tick_en(run_tick),
      .speed(speed_q),
      .spawn_en(spawn_vec[g]),
      .spawn_type(spawn_type),
      .pos(pos_all[g*POS_W +: POS_W]),
      .obs_type(type_all[g*3 +: 3]),
      .active(active[g]),
      .beyond(beyond[g])
    );
  end

  // holdoff, speed ramp and spawn pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdoff_q <= '0;
      ramp_q <= '0;
      speed_q <= SPD_INIT;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= spawn_go;
      if (clear) begin
        holdoff_q <= '0;
        ramp_q <= '0;
        speed_q <= SPD_INIT;
      end else if (run_tick) begin
        if (spawn_go)
          holdoff_q <= GAP + {{(HOLD_W-5){1'b0}}, bus.i_rng[7:3]};
        else if (holdoff_q != '0)
          holdoff_q <= holdoff_q - 1'b1;
        if (ramp_q == RAMP_END) begin
          ramp_q <= '0;
          if (speed_q < SPD_MAX) speed_q <= speed_q + 3'd1;
        end else begin
          ramp_q <= ramp_q + 1'b1;
        end
      end
    end
  end

  assign bus.o_obs_pos = pos_all;
  assign bus.o_obs_type = type_all;
  assign bus.o_obs_active = active;
  assign bus.o_speed = speed_q;
  assign bus.o_spawn_pulse = pulse_q;
endmodule

// File: tb/tb_obstacle_scheduler.sv
`timescale 1ns/1ps
// tb_obstacle_scheduler: directed scenarios; spawn
// events are checked against a queue of expected spawns.
module tb_obstacle_scheduler;
  typedef struct {
    int tick;
    int slot;
    int typ;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int miss = 0;
  int t1 = 0;
  int t2 = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  obstacle_scheduler_if #(.NUM_OBS(3), .POS_W(8)) bus1 ();
  obstacle_scheduler_if #(.NUM_OBS(3), .POS_W(8)) bus2 ();

  obstacle_scheduler dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  obstacle_scheduler #(
    .MIN_GAP(0),
    .GEN_LINE(159)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int a, input int b, input int c);
    return {8'h00, 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push1(input int t, input int s, input int ty);
    exp_t e;
    e.tick = t; e.slot = s; e.typ = ty;
    q1.push_back(e);
  endtask

  task automatic push2(input int t, input int s, input int ty);
    exp_t e;
    e.tick = t; e.slot = s; e.typ = ty;
    q2.push_back(e);
  endtask

  task automatic tick1(input int n);
    repeat (n) begin
      @(negedge clk);
      bus1.i_game_tick = 1'b1;
      t1++;
      @(negedge clk);
      bus1.i_game_tick = 1'b0;
    end
  endtask

  task automatic tick2(input int n);
    repeat (n) begin
      @(negedge clk);
      bus2.i_game_tick = 1'b1;
      t2++;
      @(negedge clk);
      bus2.i_game_tick = 1'b0;
    end
  endtask

  task automatic start1(input bit with_tick);
    @(negedge clk);
    bus1.i_game_start = 1'b1;
    bus1.i_game_tick = with_tick;
    t1 = 0;
    @(negedge clk);
    bus1.i_game_start = 1'b0;
    bus1.i_game_tick = 1'b0;
  endtask

  task automatic start2();
    @(negedge clk);
    bus2.i_game_start = 1'b1;
    t2 = 0;
    @(negedge clk);
    bus2.i_game_start = 1'b0;
  endtask

  // scoreboard for dut1 spawn events
  always @(negedge clk) begin
    if (bus1.o_spawn_pulse) begin
      vecs++;
      if (q1.size() == 0) begin
        miss++;
        $display("FAIL spawn1 unexpected at tick %0d mask %b",
                 t1, bus1.o_obs_active);
      end else begin
        e1 = q1.pop_front();
        if (t1 != e1.tick || !bus1.o_obs_active[e1.slot]
            || bus1.o_obs_pos[e1.slot*8 +: 8] != 8'd159
            || bus1.o_obs_type[e1.slot*3 +: 3] != 3'(e1.typ)) begin
          miss++;
          $display("FAIL spawn1 got tick %0d mask %b pos %h type %h want tick %0d slot %0d type %0d",
                   t1, bus1.o_obs_active, bus1.o_obs_pos,
                   bus1.o_obs_type, e1.tick, e1.slot, e1.typ);
        end
      end
    end
  end

  // scoreboard for dut2 spawn events
  always @(negedge clk) begin
    if (bus2.o_spawn_pulse) begin
      vecs++;
      if (q2.size() == 0) begin
        miss++;
        $display("FAIL spawn2 unexpected at tick %0d mask %b",
                 t2, bus2.o_obs_active);
      end else begin
        e2 = q2.pop_front();
        if (t2 != e2.tick || !bus2.o_obs_active[e2.slot]
            || bus2.o_obs_pos[e2.slot*8 +: 8] != 8'd159
            || bus2.o_obs_type[e2.slot*3 +: 3] != 3'(e2.typ)) begin
          miss++;
          $display("FAIL spawn2 got tick %0d mask %b pos %h type %h want tick %0d slot %0d type %0d",
                   t2, bus2.o_obs_active, bus2.o_obs_pos,
                   bus2.o_obs_type, e2.tick, e2.slot, e2.typ);
        end
      end
    end
  end

  initial begin
    bus1.i_game_tick = 1'b0;
    bus1.i_game_start = 1'b0;
    bus1.i_game_frozen = 1'b0;
    bus1.i_rng = 8'h00;
    bus2.i_game_tick = 1'b0;
    bus2.i_game_start = 1'b0;
    bus2.i_game_frozen = 1'b0;
    bus2.i_rng = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_pos", bus1.o_obs_pos, pk(160, 160, 160));
    chk("rst_act", bus1.o_obs_active, 0);
    chk("rst_type", bus1.o_obs_type, 0);
    chk("rst_spd", bus1.o_speed, 1);
    chk("rst_pulse", bus1.o_spawn_pulse, 0);
    rst = 1'b0;

    tick1(3);
    chk("idle_act", bus1.o_obs_active, 0);
    chk("idle_pos", bus1.o_obs_pos, pk(160, 160, 160));

    // dut2: gap 0, spawn line at 159 -> fill every slot
    start2();
    push2(1, 0, 0);
    push2(2, 1, 2);
    push2(3, 2, 3);
    bus2.i_rng = 8'h00;
    tick2(1);
    bus2.i_rng = 8'h06;
    tick2(1);
    bus2.i_rng = 8'h07;
    tick2(1);
    bus2.i_rng = 8'h00;
    chk("full_act", bus2.o_obs_active, 3'b111);
    chk("full_pos", bus2.o_obs_pos, pk(157, 158, 159));
    chk("full_type", bus2.o_obs_type, 9'b011_010_000);
    tick2(157);
    chk("full160_act", bus2.o_obs_active, 3'b111);
    chk("full160_pos", bus2.o_obs_pos, pk(0, 1, 2));
    push2(162, 0, 0);
    push2(163, 1, 0);
    push2(164, 2, 0);
    tick2(1);
    chk("exp0_act", bus2.o_obs_active, 3'b110);
    chk("exp0_pos", bus2.o_obs_pos, pk(160, 0, 1));
    tick2(1);
    chk("re0_act", bus2.o_obs_active, 3'b101);
    chk("re0_pos", bus2.o_obs_pos, pk(159, 160, 0));
    tick2(1);
    chk("re1_act", bus2.o_obs_active, 3'b011);
    chk("re1_pos", bus2.o_obs_pos, pk(158, 159, 160));
    tick2(1);
    chk("re2_act", bus2.o_obs_active, 3'b111);
    chk("re2_pos", bus2.o_obs_pos, pk(157, 158, 159));

    // dut1: first spawn with rng 00
    start1(1'b0);
    bus1.i_rng = 8'h00;
    push1(1, 0, 0);
    tick1(40);
    chk("a_act", bus1.o_obs_active, 3'b001);
    chk("a_pos", bus1.o_obs_pos, pk(120, 160, 160));
    chk("a_spd", bus1.o_speed, 1);

    // restart, rng FF: type 3, holdoff 71, line 70
    start1(1'b0);
    chk("b_clr", bus1.o_obs_active, 0);
    bus1.i_rng = 8'hFF;
    push1(1, 0, 3);
    push1(91, 1, 3);
    tick1(90);
    chk("b90_act", bus1.o_obs_active, 3'b001);
    chk("b90_pos", bus1.o_obs_pos, pk(70, 160, 160));
    tick1(1);
    chk("b91_act", bus1.o_obs_active, 3'b011);
    chk("b91_pos", bus1.o_obs_pos, pk(69, 159, 160));
    chk("b91_type", bus1.o_obs_type, 9'b000_011_011);

    // freeze for 100 ticks
    @(negedge clk);
    bus1.i_game_frozen = 1'b1;
    tick1(100);
    chk("frz_pos", bus1.o_obs_pos, pk(69, 159, 160));
    chk("frz_act", bus1.o_obs_active, 3'b011);
    chk("frz_type", bus1.o_obs_type, 9'b000_011_011);
    chk("frz_spd", bus1.o_speed, 1);
    @(negedge clk);
    bus1.i_game_frozen = 1'b0;
    @(negedge clk);
    tick1(1);
    chk("thaw_pos", bus1.o_obs_pos, pk(68, 158, 160));

    // start and tick together: clear, no movement
    start1(1'b1);
    chk("st_act", bus1.o_obs_active, 0);
    chk("st_pos", bus1.o_obs_pos, pk(160, 160, 160));
    chk("st_spd", bus1.o_speed, 1);
    bus1.i_rng = 8'h2D;
    push1(1, 0, 5);
    tick1(3);
    chk("f_pos", bus1.o_obs_pos, pk(157, 160, 160));
    chk("f_type", bus1.o_obs_type, 9'b000_000_101);

    // asynchronous reset between edges
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_act", bus1.o_obs_active, 0);
    chk("arst_pos", bus1.o_obs_pos, pk(160, 160, 160));
    chk("arst_type", bus1.o_obs_type, 0);
    @(negedge clk);
    rst = 1'b0;
    tick1(5);
    chk("post_rst_act", bus1.o_obs_active, 0);
    chk("post_rst_pos", bus1.o_obs_pos, pk(160, 160, 160));

    // speed ramp over 1906 ticks, rng 00
    start1(1'b0);
    bus1.i_rng = 8'h00;
    for (int k = 0; k < 7; k++) push1(1 + 90 * k, k % 2, 0);
    push1(616, 1, 0);
    for (int k = 0; k < 12; k++) push1(662 + 46 * k, k % 2, 0);
    for (int k = 0; 1210 + 41 * k <= 1906; k++)
      push1(1210 + 41 * k, k % 2, 0);
    tick1(599);
    chk("spd599", bus1.o_speed, 1);
    tick1(1);
    chk("spd600", bus1.o_speed, 2);
    tick1(600);
    chk("spd1200", bus1.o_speed, 3);
    tick1(600);
    chk("spd1800", bus1.o_speed, 4);
    tick1(105);
    chk("spd1905", bus1.o_speed, 4);
    chk("r1905_act", bus1.o_obs_active, 3'b001);
    chk("r1905_pos", bus1.o_obs_pos, pk(3, 160, 160));
    tick1(1);
    chk("r1906_act", bus1.o_obs_active, 0);
    chk("r1906_pos", bus1.o_obs_pos, pk(160, 160, 160));

    repeat (3) @(negedge clk);
    chk("q1_left", q1.size(), 0);
    chk("q2_left", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
